// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA stream timing block.
//   vga_timing_t : per-axis timing (display, front porch, pulse, back porch)
//   total()      : full period of one axis
//   blank_len()  : number of non-display counts before the active region
//   WHITE/BLACK  : single-bit colour levels, replicated to any pixel width
//   UF_CNT_W     : width of the saturating underflow counter
package vga_pkg;

    typedef struct packed {
        int unsigned disp;
        int unsigned fp;
        int unsigned pulse;
        int unsigned bp;
    } vga_timing_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_t;

    localparam int   UF_CNT_W = 16;
    localparam logic WHITE    = 1'b1;
    localparam logic BLACK    = 1'b0;

    function automatic int unsigned total(input vga_timing_t t);
        return t.disp + t.fp + t.pulse + t.bp;
    endfunction

    function automatic int unsigned blank_len(input vga_timing_t t);
        return t.fp + t.pulse + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the video timing.
// Counts 0..TOTAL-1 and decodes the sync and active regions; the line order
// is front porch, sync pulse, back porch, then the display area.
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   clr       hold the counter at 0 (takes priority over adv)
//   adv       advance one step this cycle
//   cnt       current count
//   tc        count is at TOTAL-1 (wraps on the next advance)
//   in_sync   count lies in the sync pulse
//   in_active count lies in the display area
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned DISP  = 800,
    parameter int unsigned FP    = 40,
    parameter int unsigned PULSE = 48,
    parameter int unsigned BP    = 40,
    parameter int          W     = $clog2(DISP + FP + PULSE + BP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         in_sync,
    output logic         in_active
);

    localparam vga_timing_t T     = '{disp: DISP, fp: FP, pulse: PULSE, bp: BP};
    localparam int unsigned TOTAL = total(T);
    localparam int unsigned BLK   = blank_len(T);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(FP);
    localparam logic [W-1:0] SYNC_HI = W'(FP + PULSE);
    localparam logic [W-1:0] ACT_LO  = W'(BLK);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_reg <= '0;
        end else if (adv) begin
            cnt_reg <= tc ? '0 : cnt_reg + W'(1);
        end
    end

    assign cnt       = cnt_reg;
    assign tc        = (cnt_reg == LAST);
    assign in_sync   = (cnt_reg >= SYNC_LO) && (cnt_reg < SYNC_HI);
    assign in_active = (cnt_reg >= ACT_LO);

endmodule

// File: rtl/vga_stream_timing.sv
// Video timing generator and pixel-stream sink for the LCD/VGA output.
// Generates HS/VS/BLANK from parametrised porch/pulse timing, pulls pixels
// from an upstream valid/ready stream during the active region, substitutes
// UF_COLOR and counts an underflow whenever a pixel is missing, and pulses
// sof so the framebuffer reader can realign. Timing never stalls.
// Ports:
//   pixel_clk, pixel_rst_n  clock and synchronous active-low reset
//   enable                  run request; dropping it finishes the frame first
//   pix_data/pix_valid      upstream pixel stream
//   pix_ready               pixel consumed this cycle (combinational)
//   test_mode               grid pattern select (only with VGA_TEST_PATTERN_EN)
//   uf_clr                  clear the sticky underflow flag
//   HS, VS, BLANK, RGB, sof registered video outputs (BLANK=1 on active pixels)
//   underflow, uf_count     sticky flag and saturating count of missing pixels
//   busy                    frame in progress
// Optional build macro: VGA_TEST_PATTERN_EN adds the internal grid pattern.
module vga_stream_timing
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VFP    = 13,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 29,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0,
    parameter int          PIX_W  = 24,
    parameter logic [PIX_W-1:0] UF_COLOR = PIX_W'(24'hFF00FF)
) (
    input  logic                pixel_clk,
    input  logic                pixel_rst_n,
    input  logic                enable,
    input  logic [PIX_W-1:0]    pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic                test_mode,
    input  logic                uf_clr,
    output logic                HS,
    output logic                VS,
    output logic                BLANK,
    output logic [PIX_W-1:0]    RGB,
    output logic                sof,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] uf_count,
    output logic                busy
);

    localparam vga_timing_t H_T    = '{disp: HDISP, fp: HFP, pulse: HPULSE, bp: HBP};
    localparam vga_timing_t V_T    = '{disp: VDISP, fp: VFP, pulse: VPULSE, bp: VBP};
    localparam int          HW     = $clog2(total(H_T));
    localparam int          VW     = $clog2(total(V_T));

    vga_state_t    state_reg, state_next;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_tc, v_tc, h_sync, v_sync, h_active, v_active;
    logic          counting, active, frame_end;
    logic          test_path, grid_hit;

    logic                hs_reg, hs_next, vs_reg, vs_next;
    logic                blank_reg, blank_next, sof_reg, sof_next;
    logic [PIX_W-1:0]    rgb_reg, rgb_next;
    logic                underflow_reg, underflow_next;
    logic [UF_CNT_W-1:0] uf_count_reg, uf_count_next;

    // Counters sit at (0,0) while idle so the first counted pixel after
    // enable is always the frame origin.
    assign counting  = (state_reg != ST_IDLE);
    assign active    = h_active && v_active;
    assign frame_end = h_tc && v_tc;

    vga_axis_counter #(
        .DISP(HDISP), .FP(HFP), .PULSE(HPULSE), .BP(HBP), .W(HW)
    ) u_h_axis (
        .clk(pixel_clk), .rst_n(pixel_rst_n), .clr(~counting), .adv(counting),
        .cnt(h_cnt), .tc(h_tc), .in_sync(h_sync), .in_active(h_active)
    );

    vga_axis_counter #(
        .DISP(VDISP), .FP(VFP), .PULSE(VPULSE), .BP(VBP), .W(VW)
    ) u_v_axis (
        .clk(pixel_clk), .rst_n(pixel_rst_n), .clr(~counting), .adv(counting && h_tc),
        .cnt(v_cnt), .tc(v_tc), .in_sync(v_sync), .in_active(v_active)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned HBLK = blank_len(H_T);
    localparam int unsigned VBLK = blank_len(V_T);
    logic [3:0] h_off, v_off;

    // Position within the display area, modulo 16: one white line every 16.
    assign h_off     = 4'(32'(h_cnt) - 32'(HBLK));
    assign v_off     = 4'(32'(v_cnt) - 32'(VBLK));
    assign grid_hit  = (h_off == 4'd0) || (v_off == 4'd0);
    assign test_path = test_mode;
`else
    // test_mode has no effect in this build.
    assign grid_hit  = 1'b0;
    assign test_path = test_mode & 1'b0;
`endif

    assign pix_ready = counting && active && !test_path;

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            // Dropping enable on the very last count needs no drain frame.
            ST_RUN:   if (!enable) state_next = frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (frame_end) state_next = enable ? ST_RUN : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output stage: everything is decoded from the current counter state and
    // registered, so all outputs trail the counters by one cycle.
    always_comb begin
        hs_next        = ~HS_POL;
        vs_next        = ~VS_POL;
        blank_next     = 1'b0;
        sof_next       = 1'b0;
        rgb_next       = {PIX_W{BLACK}};
        underflow_next = underflow_reg;
        uf_count_next  = uf_count_reg;

        // A fresh underflow below overrides the clear.
        if (uf_clr) underflow_next = 1'b0;

        if (counting) begin
            if (h_sync) hs_next = HS_POL;
            if (v_sync) vs_next = VS_POL;
            blank_next = active;
            sof_next   = (h_cnt == '0) && (v_cnt == '0);
            if (pix_ready) begin
                if (pix_valid) begin
                    rgb_next = pix_data;
                end else begin
                    rgb_next       = UF_COLOR;
                    underflow_next = 1'b1;
                    if (uf_count_reg != {UF_CNT_W{1'b1}}) begin
                        uf_count_next = uf_count_reg + UF_CNT_W'(1);
                    end
                end
            end else if (active && test_path && grid_hit) begin
                rgb_next = {PIX_W{WHITE}};
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            hs_reg        <= ~HS_POL;
            vs_reg        <= ~VS_POL;
            blank_reg     <= 1'b0;
            sof_reg       <= 1'b0;
            rgb_reg       <= '0;
            underflow_reg <= 1'b0;
            uf_count_reg  <= '0;
        end else begin
            hs_reg        <= hs_next;
            vs_reg        <= vs_next;
            blank_reg     <= blank_next;
            sof_reg       <= sof_next;
            rgb_reg       <= rgb_next;
            underflow_reg <= underflow_next;
            uf_count_reg  <= uf_count_next;
        end
    end

    assign HS        = hs_reg;
    assign VS        = vs_reg;
    assign BLANK     = blank_reg;
    assign RGB       = rgb_reg;
    assign sof       = sof_reg;
    assign underflow = underflow_reg;
    assign uf_count  = uf_count_reg;
    assign busy      = counting;

endmodule

// File: doc/vga_stream_timing.md
Name: vga_stream_timing

Overview:
Parametrised video timing generator and pixel-stream sink for the LCD/VGA output path. It generates HS, VS and BLANK from fully parametrised porch and pulse timing with selectable sync polarity. Pixels come from an upstream valid/ready stream, typically the SDRAM framebuffer reader's FIFO, and are registered onto RGB during the active region. Underflow is detected and counted, and start-of-frame is signalled so the reader can realign its address.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
PIX_W, 24, pixel width
UF_COLOR, 24'hFF00FF, RGB value driven on underflow

Ports:
pixel_clk  in  1  sole clock
pixel_rst_n  in  1  synchronous active-low reset
enable  in  1  run request
pix_data  in  PIX_W  upstream pixel
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  pixel consumed this cycle (combinational from counters)
test_mode  in  1  internal grid pattern select (see Optional Feature)
uf_clr  in  1  clear sticky underflow flag
HS  out  1  horizontal sync
VS  out  1  vertical sync
BLANK  out  1  1 = active display pixel
RGB  out  PIX_W  pixel out
sof  out  1  one-cycle start-of-frame pulse
underflow  out  1  sticky underflow flag
uf_count  out  16  saturating underflow counter
busy  out  1  frame in progress

Behaviour:
- HTOTAL = HDISP+HFP+HPULSE+HBP and VTOTAL likewise. Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL).
- h_cnt runs 0..HTOTAL-1. Regions: [0,HFP) front porch, [HFP,HFP+HPULSE) sync, then back porch, then active at h_cnt >= HBLK = HFP+HPULSE+HBP.
- v_cnt has the same structure and increments when h_cnt wraps. v_cnt wraps at VTOTAL-1.
- Reset (pixel_rst_n=0 at an edge):
  - h_cnt=v_cnt=0; state IDLE.
  - HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, sof=0, underflow=0, uf_count=0, busy=0.
- FSM IDLE / RUN / DRAIN:
  - IDLE: counters held at 0, outputs at reset values, pix_ready=0. enable=1 -> RUN. First counted pixel is (0,0) in the cycle after the transition.
  - RUN: counters advance every cycle. enable=0 -> DRAIN.
  - DRAIN: counting continues to the end of the frame. At h=HTOTAL-1, v=VTOTAL-1 go to IDLE, or to RUN if enable has returned to 1.
  - busy=1 in RUN and DRAIN.
- All outputs are registered, with 1-cycle latency from the counter state:
  - HS/VS are at active level for the sync regions.
  - BLANK=1 when both counters are in active regions.
  - sof=1 for the cycle following count (0,0).
- pix_ready = (RUN|DRAIN) & active(h_cnt,v_cnt) & ~test_path. It is asserted exactly HDISP*VDISP times per frame.
- Pixel transfer:
  - pix_ready & pix_valid: RGB <= pix_data.
  - pix_ready & ~pix_valid: RGB <= UF_COLOR, underflow <= 1, uf_count += 1, saturating at 16'hFFFF.
  - Not active: RGB <= 0.
  - The timing never stalls on underflow.
- uf_clr clears the underflow flag only, not uf_count. If uf_clr and a new underflow occur in the same cycle, the set wins.
- Reset mid-frame aborts immediately to IDLE with reset values. A partially consumed frame is not completed.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: test_mode=1 makes test_path=1, so pix_ready=0. During the active region RGB = 24'hFFFFFF when (h_cnt-HBLK)%16==0 or (v_cnt-VBLK)%16==0, else 0. No underflow is counted.
- Undefined: test_mode is ignored (test_path=0) and no pattern logic is synthesised.

Decomposition:
- Package vga_pkg:
  - typedef vga_timing_t struct (disp/fp/pulse/bp per axis).
  - functions total() and blank_len().
  - PIX_W-independent constants WHITE and BLACK, and the UF counter width of 16.
- One sub-module, vga_axis_counter, instantiated twice (h and v): wrap counter with enable, terminal-count flag and region decode (in_sync, in_active) against parameters DISP, FP, PULSE and BP.

Test Plan:
Bench parameters: HDISP=4, VDISP=2, all porches and pulses =1, so HTOTAL=7 and VTOTAL=5.
- Reset then enable=1, pix_valid=1 with pix_data = incrementing 1..8 -> RGB shows 1..8 with BLANK=1 exactly 8 cycles per 35-cycle frame, sof high once every 35 cycles, HS low 1 cycle in 7.
- pix_valid dropped for one active pixel -> RGB=FF00FF that cycle, underflow=1, uf_count=1. Timing unchanged (next sof still 35 cycles after the previous one).
- uf_clr asserted in the same cycle as a second underflow -> underflow stays 1, uf_count=2. uf_clr alone next cycle -> underflow=0, uf_count=2.
- enable deasserted at v=1 -> busy stays 1 until end of frame, then IDLE with HS=VS=1 and no further pix_ready.
- pixel_rst_n=0 at h=5, v=3 -> next cycle all outputs at reset values and counters at 0.
- With VGA_TEST_PATTERN_EN and test_mode=1 -> pix_ready never asserted. RGB=FFFFFF at active x=0 and on active line y=0, else 0. uf_count stays 0.
